// File: rtl/csd_term_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : csd_term_encoder_if
// Brief    : Operand-in / term-record-out bus of the CSD (NAF) term encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface csd_term_encoder_if #(
    parameter int B_N = 15,
    parameter int N   = 4
);
    logic [B_N-1:0] b;
    logic           in_vld;
    logic           in_rdy;
    logic [N-1:0]   b_i;
    logic [N-1:0]   b_j;
    logic           b_sign;
    logic           one_term;
    logic           term_neg;
    logic           empty;
    logic           last;
    logic           out_vld;
    logic           out_rdy;

    // master: operand source and record sink; slave: the encoder itself
    modport master (
        output b, in_vld, out_rdy,
        input  in_rdy, b_i, b_j, b_sign, one_term, term_neg, empty, last, out_vld
    );

    modport slave (
        input  b, in_vld, out_rdy,
        output in_rdy, b_i, b_j, b_sign, one_term, term_neg, empty, last, out_vld
    );
endinterface
`default_nettype wire

// File: rtl/csd_term_encoder.sv
`default_nettype none
// ============================================================================
// Module   : csd_term_encoder
// Brief    : Recodes b into non-adjacent form, streaming pairs of digits as
//            a<<b_i +/- a<<b_j term records for a two-term multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module csd_term_encoder #(
    parameter int B_N = 15,
    parameter int N   = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    csd_term_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    localparam logic [B_N:0] c_X_ONE = (B_N+1)'(1);
    localparam logic [N-1:0] c_POS_ONE = N'(1);

    state_t         r_state;
    logic [B_N:0]   r_x;
    logic [N-1:0]   r_pos;
    logic           r_pend;
    logic [N-1:0]   r_pend_pos;
    logic           r_pend_neg;

    logic [N-1:0]   r_b_i;
    logic [N-1:0]   r_b_j;
    logic           r_b_sign;
    logic           r_one_term;
    logic           r_term_neg;
    logic           r_empty;
    logic           r_last;
    logic           r_out_vld;

    // Odd x with bit1 set takes digit -1 (x+1 carries), otherwise +1 (x-1);
    // either way the low bit is consumed by the shift.
    logic           w_neg;
    logic [B_N:0]   w_x_next;
    logic           w_x_done;

    assign w_neg    = r_x[0] & r_x[1];
    assign w_x_next = w_neg ? ((r_x + c_X_ONE) >> 1) : (r_x >> 1);
    assign w_x_done = (w_x_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_pos      <= '0;
            r_pend     <= 1'b0;
            r_pend_pos <= '0;
            r_pend_neg <= 1'b0;
            r_b_i      <= '0;
            r_b_j      <= '0;
            r_b_sign   <= 1'b0;
            r_one_term <= 1'b0;
            r_term_neg <= 1'b0;
            r_empty    <= 1'b0;
            r_last     <= 1'b0;
            r_out_vld  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_vld) begin
                        r_x    <= {1'b0, bus.b};
                        r_pos  <= '0;
                        r_pend <= 1'b0;
                        if (bus.b == '0) begin
                            r_b_i      <= '0;
                            r_b_j      <= '0;
                            r_b_sign   <= 1'b0;
                            r_one_term <= 1'b1;
                            r_term_neg <= 1'b0;
                            r_empty    <= 1'b1;
                            r_last     <= 1'b1;
                            r_out_vld  <= 1'b1;
                            r_state    <= S_EMIT;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end

                S_SCAN: begin
                    r_x   <= w_x_next;
                    r_pos <= r_pos + c_POS_ONE;
                    if (r_x[0]) begin
                        if (!r_pend) begin
                            if (w_x_done) begin
                                r_b_i      <= r_pos;
                                r_b_j      <= '0;
                                r_b_sign   <= 1'b0;
                                r_one_term <= 1'b1;
                                r_term_neg <= w_neg;
                                r_empty    <= 1'b0;
                                r_last     <= 1'b1;
                                r_out_vld  <= 1'b1;
                                r_state    <= S_EMIT;
                            end else begin
                                r_pend     <= 1'b1;
                                r_pend_pos <= r_pos;
                                r_pend_neg <= w_neg;
                            end
                        end else begin
                            r_pend     <= 1'b0;
                            r_one_term <= 1'b0;
                            r_empty    <= 1'b0;
                            r_last     <= w_x_done;
                            r_out_vld  <= 1'b1;
                            r_state    <= S_EMIT;
                            if (w_neg == r_pend_neg) begin
                                // like signs: magnitude is a sum, sign goes to the accumulator
                                r_b_i      <= r_pos;
                                r_b_j      <= r_pend_pos;
                                r_b_sign   <= 1'b0;
                                r_term_neg <= w_neg;
                            end else if (!w_neg) begin
                                r_b_i      <= r_pos;
                                r_b_j      <= r_pend_pos;
                                r_b_sign   <= 1'b1;
                                r_term_neg <= 1'b0;
                            end else begin
                                r_b_i      <= r_pend_pos;
                                r_b_j      <= r_pos;
                                r_b_sign   <= 1'b1;
                                r_term_neg <= 1'b0;
                            end
                        end
                    end
                end

                S_EMIT: begin
                    if (bus.out_rdy) begin
                        r_out_vld <= 1'b0;
                        r_state   <= r_last ? S_IDLE : S_SCAN;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_rdy   = (r_state == S_IDLE);
    assign bus.b_i      = r_b_i;
    assign bus.b_j      = r_b_j;
    assign bus.b_sign   = r_b_sign;
    assign bus.one_term = r_one_term;
    assign bus.term_neg = r_term_neg;
    assign bus.empty    = r_empty;
    assign bus.last     = r_last;
    assign bus.out_vld  = r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_csd_term_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_csd_term_encoder
// Brief    : Scoreboard bench for csd_term_encoder: directed records plus
//            random operands summed through a two-term multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csd_term_encoder;

    localparam int B_N = 15;
    localparam int N   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csd_term_encoder_if #(.B_N(B_N), .N(N)) bus ();

    csd_term_encoder #(.B_N(B_N), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          full;
        logic [12:0] rec;
        longint      a;
        longint      prod;
    } exp_t;

    exp_t   sbq[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     rdy_mode = 0;

    function automatic logic [12:0] pack(input int bi, input int bj, input int sg,
                                         input int one, input int neg, input int emp,
                                         input int lst);
        pack = {4'(bi), 4'(bj), 1'(sg), 1'(one), 1'(neg), 1'(emp), 1'(lst)};
    endfunction

    function automatic logic [12:0] dut_rec();
        dut_rec = {bus.b_i, bus.b_j, bus.b_sign, bus.one_term, bus.term_neg,
                   bus.empty, bus.last};
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic push_rec(input int bi, input int bj, input int sg, input int one,
                            input int neg, input int emp, input int lst);
        exp_t e;
        e.full = 1'b1;
        e.rec  = pack(bi, bj, sg, one, neg, emp, lst);
        e.a    = 0;
        e.prod = 0;
        sbq.push_back(e);
    endtask

    task automatic send(input logic [B_N-1:0] v);
        int n = 0;
        @(negedge clk);
        while (!bus.in_rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_rdy) begin
            n_checks++;
            $display("FAIL send_timeout: in_rdy got 0 required 1 for b=0x%0h", v);
        end else begin
            bus.b      = v;
            bus.in_vld = 1'b1;
            @(posedge clk);
            #1;
            bus.in_vld = 1'b0;
        end
    endtask

    // Downstream ready pattern
    initial begin
        bus.out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.out_rdy = ~bus.out_rdy;
                2:       bus.out_rdy = ($urandom_range(0, 3) != 0);
                default: bus.out_rdy = 1'b1;
            endcase
        end
    end

    // Monitor: stability while stalled, then pop/compare at every handshake
    initial begin
        logic [12:0] held;
        bit          hold_v;
        longint      acc;
        longint      vi, vj, v;
        exp_t        e;
        hold_v = 1'b0;
        held   = '0;
        acc    = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
                acc    = 0;
            end else begin
                if (hold_v && bus.out_vld) chk("hold_stable", dut_rec(), held);
                hold_v = bus.out_vld && !bus.out_rdy;
                held   = dut_rec();
                if (bus.out_vld && bus.out_rdy) begin
                    chk("in_rdy_while_pending", bus.in_rdy, 0);
                    if (sbq.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_record: got rec 0x%0h required none", dut_rec());
                    end else if (sbq[0].full) begin
                        e = sbq.pop_front();
                        chk("record{bi,bj,sign,one,neg,empty,last}", dut_rec(), e.rec);
                    end else begin
                        vi = sbq[0].a << bus.b_i;
                        vj = sbq[0].a << bus.b_j;
                        if (bus.empty)         v = 0;
                        else if (bus.one_term) v = vi;
                        else if (bus.b_sign)   v = vi - vj;
                        else                   v = vi + vj;
                        acc = bus.term_neg ? acc - v : acc + v;
                        if (bus.last) begin
                            e = sbq.pop_front();
                            chk("product", acc, e.prod);
                            acc = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int     stale;
        int     n;
        exp_t   e;
        longint av, bv;

        bus.b      = '0;
        bus.in_vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_rdy", bus.in_rdy, 1);
        chk("reset_out_vld", bus.out_vld, 0);
        chk("reset_record", dut_rec(), 0);

        // Reset in the middle of scanning 0x0555: nothing must come out
        send(15'h0555);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_vld", bus.out_vld, 0);
        chk("async_reset_in_rdy", bus.in_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_out_vld", bus.out_vld, 0);
        chk("post_reset_in_rdy", bus.in_rdy, 1);
        stale = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_vld) stale = 1;
        end
        chk("no_stale_record", stale, 0);

        // Directed operands
        push_rec(3, 0, 1, 0, 0, 0, 1);
        send(15'd7);
        push_rec(2, 0, 0, 0, 1, 0, 0);
        push_rec(4, 0, 0, 1, 0, 0, 1);
        send(15'd11);
        push_rec(0, 0, 0, 1, 0, 1, 1);
        send(15'd0);
        push_rec(15, 0, 1, 0, 0, 0, 1);
        send(15'h7FFF);
        push_rec(0, 0, 0, 1, 0, 0, 1);
        send(15'd1);
        push_rec(2, 0, 1, 0, 0, 0, 1);
        send(15'd3);
        push_rec(14, 0, 0, 1, 0, 0, 1);
        send(15'h4000);
        push_rec(0, 2, 1, 0, 0, 0, 0);
        push_rec(4, 0, 0, 1, 0, 0, 1);
        send(15'd13);
        // in_vld while busy must be ignored
        @(negedge clk);
        bus.b      = 15'd9;
        bus.in_vld = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_vld = 1'b0;

        rdy_mode = 1;
        push_rec(2, 0, 0, 0, 0, 0, 0);
        push_rec(6, 4, 0, 0, 0, 0, 0);
        push_rec(10, 8, 0, 0, 0, 0, 1);
        send(15'h0555);

        // Random operands through the multiplier model
        for (int i = 0; i < 1000; i++) begin
            rdy_mode = (i % 3 == 0) ? 2 : (i % 3);
            av = longint'($urandom_range(0, 65535));
            bv = longint'($urandom_range(0, 32767));
            e.full = 1'b0;
            e.rec  = '0;
            e.a    = av;
            e.prod = av * bv;
            sbq.push_back(e);
            send(B_N'(bv));
        end

        n = 0;
        while (sbq.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d outstanding required 0", sbq.size());
        end
        repeat (3) @(negedge clk);
        chk("final_in_rdy", bus.in_rdy, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
